ifc_regbank_arbiter: RTL and testbench
======================================

// Module: ifc_regbank_arbiter
// PURPOSE
//  Arbitrates the CPLD's single-port 16-bit register bank between two requesters.
//  Requester 0 is the IFC local-bus slave front end (host reads/writes, priority).
//  Requester 1 is the UART command decoder (maintenance access).
//  Sequences each bank access and returns read data plus a one-cycle ack per requester.
//  Guarantees the UART port makes progress under continuous host traffic.
// PARAMETERS
//  RD_LAT     1    register-bank read latency in cycles, 1..4
//  NUM_REGS   64   implemented registers; addresses >= NUM_REGS are decode errors
//  STARVE_MAX 4    consecutive IFC grants with UART pending before UART is forced
//  ERR_DATA   16'hDEAD  read data returned on decode error
// PORTS
//  clock_50MHz  in   1   system clock, all logic on rising edge
//  rst_n        in   1   synchronous reset, active low
//  ifc_req      in   1   IFC request; hold high with fields stable until ifc_ack
//  ifc_we       in   1   1=write, 0=read
//  ifc_addr     in   8   register address (already bit-order corrected)
//  ifc_wdata    in   16  write data
//  ifc_ack      out  1   one-cycle completion pulse
//  ifc_rdata    out  16  read data, valid in ack cycle, held until next IFC read ack
//  ifc_err      out  1   decode error, valid in ack cycle only
//  uart_req / uart_we / uart_addr / uart_wdata  in   same as IFC set
//  uart_ack / uart_rdata / uart_err             out  same as IFC set
//  reg_en       out  1   bank access strobe, one cycle per access
//  reg_we       out  1   bank write enable, qualified by reg_en
//  reg_addr     out  8   bank address
//  reg_wdata    out  16  bank write data
//  reg_rdata    in   16  bank read data, valid RD_LAT cycles after the reg_en cycle
//  busy         out  1   1 in any state other than IDLE
//  owner        out  1   0=IFC, 1=UART; current/last grant
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; starve counter=0; captured rdata=0.
//  FSM: IDLE -> ACCESS -> (read: WAIT x RD_LAT) -> RESP -> IDLE.
//   IDLE: arbitrate; the grant latches we/addr/wdata/owner.
//   ACCESS: reg_en=1 one cycle; outputs stay registered.
//   WAIT: count RD_LAT cycles; reg_rdata captured at the end of the last WAIT cycle.
//   RESP: owner's ack=1 one cycle; owner's rdata updated on reads only.
//  Cycle 0 = IDLE cycle with req sampled high.
//  Latency: write ack in cycle 2; read ack in cycle 2+RD_LAT (RD_LAT=1 -> cycle 3).
//  Decode error (addr >= NUM_REGS):
//   - ACCESS runs with reg_en=0, WAIT is skipped, RESP follows in cycle 2.
//   - err=1 in the ack cycle; reads return ERR_DATA; writes are dropped.
//  Arbitration in IDLE only:
//   - only one req high -> grant it.
//   - both high -> grant IFC, unless starve_cnt==STARVE_MAX -> grant UART.
//  starve_cnt:
//   - +1 on an IFC grant while uart_req=1, saturates at STARVE_MAX.
//   - cleared on a UART grant or on an IFC grant with uart_req=0.
//  Handshake:
//   - req and fields are sampled only in IDLE; changes while not granted are ignored.
//   - req still high in the IDLE after RESP is a new transaction.
//   - so back-to-back period = 3 cycles for writes, 3+RD_LAT for reads.
//  Requester dropping req before ack: the transaction still completes and acks.
//  No more than one transaction is ever outstanding; the other ack stays 0.
//  Reset mid-operation: FSM -> IDLE on the next edge with no ack.
//   - a reg_en already issued to the bank is not undone.
// TESTING
//  1 IFC write 0x22<-0x1234, RD_LAT=1: reg_en/reg_we high in cycle 1; ifc_ack in cycle 2.
//  2 IFC read 0x22 after 1: ifc_ack in cycle 3; ifc_rdata=0x1234; uart_ack stays 0.
//  3 Both req on the same edge: IFC served first, UART granted in the IDLE after IFC RESP.
//  4 IFC req held high, uart_req high, STARVE_MAX=4:
//     4 IFC grants, then 1 UART grant, then IFC resumes.
//  5 UART read addr 0x50 (NUM_REGS=64): reg_en never asserts; uart_ack+uart_err in cycle 2;
//     uart_rdata=0xDEAD.
//  6 rst_n low during WAIT: FSM idle next cycle, no ack, starve_cnt=0;
//     a pending req is re-granted after release.

Source files
------------

// File: rtl/ifc_regbank_arbiter_if.sv
// Request/response bundle for one requester of the shared register bank.
// The requester drives the master side; the arbiter implements the slave side.
interface ifc_regbank_arbiter_if;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err
  );
endinterface

// File: rtl/ifc_regbank_arbiter.sv
// Shares the single-port 16-bit register bank between the IFC host port (priority)
// and the UART maintenance port, with starvation relief for the UART side.
//
// state  | meaning
// IDLE   | arbitrate; a grant latches we/addr/wdata/owner
// ACCESS | bank strobe for one cycle (suppressed on decode error)
// WAIT   | RD_LAT cycles of bank read latency; data captured in the last one
// RESP   | one-cycle ack to the owner
module ifc_regbank_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned NUM_REGS   = 64,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [15:0] ERR_DATA   = 16'hDEAD
) (
  input  logic                        clock_50MHz_i,
  input  logic                        rst_n_i,
  ifc_regbank_arbiter_if.slave        ifc_bus,
  ifc_regbank_arbiter_if.slave        uart_bus,
  output logic                        reg_en_o,
  output logic                        reg_we_o,
  output logic [7:0]                  reg_addr_o,
  output logic [15:0]                 reg_wdata_o,
  input  logic [15:0]                 reg_rdata_i,
  output logic                        busy_o,
  output logic                        owner_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] WAIT_LOAD  = 2'(RD_LAT - 1);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic [1:0]  state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic [7:0]  starve_q, starve_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        reg_en_q, reg_en_d;
  logic        reg_we_q, reg_we_d;
  logic        ifc_ack_q, ifc_ack_d;
  logic        uart_ack_q, uart_ack_d;
  logic        ifc_err_q, ifc_err_d;
  logic        uart_err_q, uart_err_d;
  logic [15:0] ifc_rdata_q, ifc_rdata_d;
  logic [15:0] uart_rdata_q, uart_rdata_d;

  logic        uart_forced;
  logic        grant_ifc;
  logic        grant_uart;
  logic        sel_we;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_err;

  logic        rsp_fire;
  logic        rsp_load;
  logic [15:0] rsp_data;

  // UART wins a contested cycle only once the IFC has been favoured STARVE_MAX times in a row.
  assign uart_forced = uart_bus.req && (starve_q == STARVE_LIM);
  assign grant_ifc   = ifc_bus.req && !uart_forced;
  assign grant_uart  = uart_bus.req && !grant_ifc;

  assign sel_we    = grant_uart ? uart_bus.we    : ifc_bus.we;
  assign sel_addr  = grant_uart ? uart_bus.addr  : ifc_bus.addr;
  assign sel_wdata = grant_uart ? uart_bus.wdata : ifc_bus.wdata;
  assign sel_err   = ({1'b0, sel_addr} >= NUM_REGS_W);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    starve_d     = starve_q;
    owner_d      = owner_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    reg_en_d     = 1'b0;
    reg_we_d     = 1'b0;
    ifc_ack_d    = 1'b0;
    uart_ack_d   = 1'b0;
    ifc_err_d    = 1'b0;
    uart_err_d   = 1'b0;
    ifc_rdata_d  = ifc_rdata_q;
    uart_rdata_d = uart_rdata_q;
    rsp_fire     = 1'b0;
    rsp_load     = 1'b0;
    rsp_data     = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_ifc || grant_uart) begin
          state_d  = S_ACCESS;
          owner_d  = grant_uart;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          err_d    = sel_err;
          reg_en_d = !sel_err;
          reg_we_d = sel_we && !sel_err;
          if (grant_ifc && uart_bus.req) begin
            if (starve_q < STARVE_LIM) starve_d = starve_q + 8'd1;
          end else begin
            starve_d = '0;
          end
        end
      end

      S_ACCESS: begin
        if (err_q) begin
          state_d  = S_RESP;
          rsp_fire = 1'b1;
          rsp_load = !we_q;
          rsp_data = ERR_DATA;
        end else if (we_q) begin
          state_d  = S_RESP;
          rsp_fire = 1'b1;
        end else begin
          state_d = S_WAIT;
          wait_d  = WAIT_LOAD;
        end
      end

      S_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d  = S_RESP;
          rsp_fire = 1'b1;
          rsp_load = 1'b1;
          rsp_data = reg_rdata_i;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ack, error and read data are registered so they all appear together in RESP.
    if (rsp_fire) begin
      if (owner_q) begin
        uart_ack_d = 1'b1;
        uart_err_d = err_q;
        if (rsp_load) uart_rdata_d = rsp_data;
      end else begin
        ifc_ack_d = 1'b1;
        ifc_err_d = err_q;
        if (rsp_load) ifc_rdata_d = rsp_data;
      end
    end
  end

  always_ff @(posedge clock_50MHz_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      starve_q     <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      reg_en_q     <= 1'b0;
      reg_we_q     <= 1'b0;
      ifc_ack_q    <= 1'b0;
      uart_ack_q   <= 1'b0;
      ifc_err_q    <= 1'b0;
      uart_err_q   <= 1'b0;
      ifc_rdata_q  <= '0;
      uart_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      starve_q     <= starve_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      reg_en_q     <= reg_en_d;
      reg_we_q     <= reg_we_d;
      ifc_ack_q    <= ifc_ack_d;
      uart_ack_q   <= uart_ack_d;
      ifc_err_q    <= ifc_err_d;
      uart_err_q   <= uart_err_d;
      ifc_rdata_q  <= ifc_rdata_d;
      uart_rdata_q <= uart_rdata_d;
    end
  end

  assign reg_en_o    = reg_en_q;
  assign reg_we_o    = reg_we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;

  assign ifc_bus.ack    = ifc_ack_q;
  assign ifc_bus.err    = ifc_err_q;
  assign ifc_bus.rdata  = ifc_rdata_q;
  assign uart_bus.ack   = uart_ack_q;
  assign uart_bus.err   = uart_err_q;
  assign uart_bus.rdata = uart_rdata_q;

endmodule

// File: tb/tb_ifc_regbank_arbiter.sv
// Self-checking bench for ifc_regbank_arbiter: directed scenarios plus random
// single-requester traffic checked against a register-array reference model.
`timescale 1ns/1ps
module tb_ifc_regbank_arbiter;
  localparam int          RD_LAT     = 1;
  localparam int          NUM_REGS   = 64;
  localparam int          STARVE_MAX = 4;
  localparam logic [15:0] ERR_DATA   = 16'hDEAD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  ifc_regbank_arbiter_if ifc_bus ();
  ifc_regbank_arbiter_if uart_bus ();

  logic        reg_en, reg_we, busy, owner;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = 16'h0000;

  ifc_regbank_arbiter #(
    .RD_LAT(RD_LAT), .NUM_REGS(NUM_REGS), .STARVE_MAX(STARVE_MAX), .ERR_DATA(ERR_DATA)
  ) dut (
    .clock_50MHz_i(clk),
    .rst_n_i      (rst_n),
    .ifc_bus      (ifc_bus),
    .uart_bus     (uart_bus),
    .reg_en_o     (reg_en),
    .reg_we_o     (reg_we),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .reg_rdata_i  (reg_rdata),
    .busy_o       (busy),
    .owner_o      (owner)
  );

  // Register bank with one cycle of read latency.
  logic [15:0] bank_mem [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (reg_en) begin
      if (reg_we) bank_mem[reg_addr] <= reg_wdata;
      reg_rdata <= bank_mem[reg_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [256] = '{default: 16'h0000};
  logic [15:0] ref_last_rd [2];

  // Runs one transaction from an idle negedge; returns what was observed.
  task automatic do_txn(input bit port, input bit we, input logic [7:0] addr, input logic [15:0] wdata,
                        output int ack_cyc, output logic [15:0] rdata, output logic err,
                        output int en_cnt, output int en_cyc, output logic en_we, output bit other_ack);
    bit done;
    ack_cyc = -1; rdata = '0; err = 1'b0; en_cnt = 0; en_cyc = -1; en_we = 1'b0; other_ack = 1'b0;
    done = 1'b0;
    if (port) begin
      uart_bus.we = we; uart_bus.addr = addr; uart_bus.wdata = wdata; uart_bus.req = 1'b1;
    end else begin
      ifc_bus.we = we; ifc_bus.addr = addr; ifc_bus.wdata = wdata; ifc_bus.req = 1'b1;
    end
    for (int c = 1; c <= 30 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (port) begin
          uart_bus.we = ~we; uart_bus.addr = 8'($urandom); uart_bus.wdata = 16'($urandom);
        end else begin
          ifc_bus.we = ~we; ifc_bus.addr = 8'($urandom); ifc_bus.wdata = 16'($urandom);
        end
      end
      if (reg_en) begin
        en_cnt++;
        if (en_cyc < 0) begin en_cyc = c; en_we = reg_we; end
      end
      if (port ? ifc_bus.ack : uart_bus.ack) other_ack = 1'b1;
      if (port ? uart_bus.ack : ifc_bus.ack) begin
        ack_cyc = c;
        rdata   = port ? uart_bus.rdata : ifc_bus.rdata;
        err     = port ? uart_bus.err : ifc_bus.err;
        done    = 1'b1;
      end
    end
    ifc_bus.req = 1'b0;
    uart_bus.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    ifc_bus.req = 0; ifc_bus.we = 0; ifc_bus.addr = '0; ifc_bus.wdata = '0;
    uart_bus.req = 0; uart_bus.we = 0; uart_bus.addr = '0; uart_bus.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc_bus.ack, ifc_bus.err, uart_bus.ack, uart_bus.err, reg_en, reg_we, busy, owner} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {ifc_bus.ack, ifc_bus.err, uart_bus.ack, uart_bus.err, reg_en, reg_we, busy, owner});
    end
    checks++;
    if (ifc_bus.rdata !== 16'h0 || uart_bus.rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got ifc %h uart %h expected 0000", ifc_bus.rdata, uart_bus.rdata);
    end
    checks++;
    if (reg_addr !== 8'h0 || reg_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_bank_bus: got addr %h wdata %h expected 0", reg_addr, reg_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b expected 0", busy);
    end
    ref_last_rd[0] = 16'h0;
    ref_last_rd[1] = 16'h0;
  endtask

  task automatic test_write_read;
    int ack_cyc, en_cnt, en_cyc; logic [15:0] rd; logic er, en_we; bit oth;
    do_txn(1'b0, 1'b1, 8'h22, 16'h1234, ack_cyc, rd, er, en_cnt, en_cyc, en_we, oth);
    ref_mem[8'h22] = 16'h1234;
    checks++;
    if (en_cyc !== 1 || en_we !== 1'b1 || en_cnt !== 1) begin
      errors++;
      $display("FAIL wr_strobe: got en_cyc %0d we %b count %0d expected 1 1 1", en_cyc, en_we, en_cnt);
    end
    checks++;
    if (ack_cyc !== 2 || er !== 1'b0 || oth) begin
      errors++;
      $display("FAIL wr_ack: got cycle %0d err %b other %0d expected 2 0 0", ack_cyc, er, oth);
    end
    do_txn(1'b0, 1'b0, 8'h22, 16'h0, ack_cyc, rd, er, en_cnt, en_cyc, en_we, oth);
    ref_last_rd[0] = 16'h1234;
    checks++;
    if (ack_cyc !== 2 + RD_LAT) begin
      errors++;
      $display("FAIL rd_ack_cycle: got %0d expected %0d", ack_cyc, 2 + RD_LAT);
    end
    checks++;
    if (rd !== 16'h1234 || oth) begin
      errors++;
      $display("FAIL rd_data: got %h other_ack %0d expected 1234 0", rd, oth);
    end
  endtask

  task automatic test_decode_err;
    int ack_cyc, en_cnt, en_cyc; logic [15:0] rd; logic er, en_we; bit oth;
    do_txn(1'b1, 1'b0, 8'h50, 16'h0, ack_cyc, rd, er, en_cnt, en_cyc, en_we, oth);
    ref_last_rd[1] = ERR_DATA;
    checks++;
    if (en_cnt !== 0 || ack_cyc !== 2 || er !== 1'b1 || rd !== ERR_DATA) begin
      errors++;
      $display("FAIL err_read: got en %0d cycle %0d err %b data %h expected 0 2 1 %h",
               en_cnt, ack_cyc, er, rd, ERR_DATA);
    end
    do_txn(1'b1, 1'b1, 8'd64, 16'hBEEF, ack_cyc, rd, er, en_cnt, en_cyc, en_we, oth);
    checks++;
    if (en_cnt !== 0 || ack_cyc !== 2 || er !== 1'b1 || rd !== ERR_DATA) begin
      errors++;
      $display("FAIL err_write: got en %0d cycle %0d err %b data %h expected 0 2 1 %h",
               en_cnt, ack_cyc, er, rd, ERR_DATA);
    end
    do_txn(1'b0, 1'b1, 8'd63, 16'h5A5A, ack_cyc, rd, er, en_cnt, en_cyc, en_we, oth);
    ref_mem[63] = 16'h5A5A;
    checks++;
    if (en_cnt !== 1 || ack_cyc !== 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL last_reg_write: got en %0d cycle %0d err %b expected 1 2 0", en_cnt, ack_cyc, er);
    end
    do_txn(1'b1, 1'b0, 8'd63, 16'h0, ack_cyc, rd, er, en_cnt, en_cyc, en_we, oth);
    ref_last_rd[1] = 16'h5A5A;
    checks++;
    if (ack_cyc !== 2 + RD_LAT || er !== 1'b0 || rd !== 16'h5A5A) begin
      errors++;
      $display("FAIL last_reg_read: got cycle %0d err %b data %h expected %0d 0 5a5a",
               ack_cyc, er, rd, 2 + RD_LAT);
    end
  endtask

  task automatic test_both_same_edge;
    int ifc_cyc, uart_cyc; logic own1, own4; logic [15:0] urd, wd; bit done;
    ifc_cyc = -1; uart_cyc = -1; own1 = 1'bx; own4 = 1'bx; urd = '0; done = 1'b0;
    wd = 16'($urandom);
    ifc_bus.we = 1'b1; ifc_bus.addr = 8'h10; ifc_bus.wdata = wd; ifc_bus.req = 1'b1;
    uart_bus.we = 1'b0; uart_bus.addr = 8'h22; uart_bus.wdata = '0; uart_bus.req = 1'b1;
    for (int c = 1; c <= 30 && !done; c++) begin
      @(negedge clk);
      if (c == 1) own1 = owner;
      if (c == 4) own4 = owner;
      if (ifc_bus.ack && ifc_cyc < 0) begin ifc_cyc = c; ifc_bus.req = 1'b0; end
      if (uart_bus.ack) begin uart_cyc = c; urd = uart_bus.rdata; uart_bus.req = 1'b0; done = 1'b1; end
    end
    ifc_bus.req = 1'b0; uart_bus.req = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc_cyc !== 2 || uart_cyc !== 4 + 2 + RD_LAT - 1) begin
      errors++;
      $display("FAIL both_order: got ifc %0d uart %0d expected 2 %0d", ifc_cyc, uart_cyc, 5 + RD_LAT);
    end
    checks++;
    if (own1 !== 1'b0 || own4 !== 1'b1) begin
      errors++;
      $display("FAIL both_owner: got %b %b expected 0 1", own1, own4);
    end
    checks++;
    if (urd !== ref_mem[8'h22]) begin
      errors++;
      $display("FAIL both_uart_data: got %h expected %h", urd, ref_mem[8'h22]);
    end
    ref_mem[8'h10] = wd;
    ref_last_rd[1] = ref_mem[8'h22];
  endtask

  task automatic test_random;
    int ack_cyc, en_cnt, en_cyc, exp_cyc; logic [15:0] rd, wd, exp_rd; logic er, en_we; bit oth;
    bit port, we, exp_err; logic [7:0] addr;
    for (int n = 0; n < 40; n++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 79));
      wd   = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_err = (int'(addr) >= NUM_REGS);
      exp_cyc = (exp_err || we) ? 2 : 2 + RD_LAT;
      if (we) exp_rd = ref_last_rd[port];
      else    exp_rd = exp_err ? ERR_DATA : ref_mem[addr];
      do_txn(port, we, addr, wd, ack_cyc, rd, er, en_cnt, en_cyc, en_we, oth);
      if (!we) ref_last_rd[port] = exp_rd;
      if (we && !exp_err) ref_mem[addr] = wd;
      checks++;
      if (ack_cyc !== exp_cyc) begin
        errors++;
        $display("FAIL rnd_ack_cycle[%0d]: got %0d expected %0d", n, ack_cyc, exp_cyc);
      end
      checks++;
      if (er !== exp_err) begin
        errors++;
        $display("FAIL rnd_err[%0d]: got %b expected %b", n, er, exp_err);
      end
      checks++;
      if (rd !== exp_rd) begin
        errors++;
        $display("FAIL rnd_rdata[%0d]: got %h expected %h (port %0d we %0d addr %h)", n, rd, exp_rd, port, we, addr);
      end
      checks++;
      if (en_cnt !== (exp_err ? 0 : 1) || (!exp_err && en_we !== we)) begin
        errors++;
        $display("FAIL rnd_strobe[%0d]: got count %0d we %b expected %0d %b", n, en_cnt, en_we, exp_err ? 0 : 1, we);
      end
      checks++;
      if (oth) begin
        errors++;
        $display("FAIL rnd_other_ack[%0d]: got 1 expected 0", n);
      end
    end
  endtask

  task automatic test_starve;
    int seq [6]; int cyc [6]; logic [15:0] dat [6]; int nacks;
    nacks = 0;
    ifc_bus.we = 1'b0; ifc_bus.addr = 8'h22; ifc_bus.req = 1'b1;
    uart_bus.we = 1'b0; uart_bus.addr = 8'h10; uart_bus.req = 1'b1;
    for (int c = 1; c <= 60 && nacks < 6; c++) begin
      @(negedge clk);
      if (ifc_bus.ack || uart_bus.ack) begin
        seq[nacks] = uart_bus.ack ? (ifc_bus.ack ? 2 : 1) : 0;
        cyc[nacks] = c;
        dat[nacks] = uart_bus.ack ? uart_bus.rdata : ifc_bus.rdata;
        nacks++;
      end
    end
    ifc_bus.req = 1'b0; uart_bus.req = 1'b0;
    @(negedge clk);
    checks++;
    if (nacks !== 6) begin
      errors++;
      $display("FAIL starve_count: got %0d acks expected 6", nacks);
    end
    for (int k = 0; k < nacks; k++) begin
      checks++;
      if (seq[k] !== ((k == STARVE_MAX) ? 1 : 0) || cyc[k] !== 3 + k * (3 + RD_LAT)) begin
        errors++;
        $display("FAIL starve_grant[%0d]: got port %0d cycle %0d expected %0d %0d",
                 k, seq[k], cyc[k], (k == STARVE_MAX) ? 1 : 0, 3 + k * (3 + RD_LAT));
      end
      checks++;
      if (dat[k] !== ((k == STARVE_MAX) ? ref_mem[8'h10] : ref_mem[8'h22])) begin
        errors++;
        $display("FAIL starve_data[%0d]: got %h expected %h", k, dat[k],
                 (k == STARVE_MAX) ? ref_mem[8'h10] : ref_mem[8'h22]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int ack_cyc, en_cnt, en_cyc; logic [15:0] rd; logic er, en_we; bit oth;
    int seq [5]; int first_cyc; int nacks;
    // Lone IFC grant clears whatever starvation count the previous scenario left.
    do_txn(1'b0, 1'b0, 8'h22, 16'h0, ack_cyc, rd, er, en_cnt, en_cyc, en_we, oth);
    nacks = 0;
    ifc_bus.we = 1'b0; ifc_bus.addr = 8'h22; ifc_bus.req = 1'b1;
    uart_bus.we = 1'b0; uart_bus.addr = 8'h10; uart_bus.req = 1'b1;
    for (int c = 1; c <= 40 && nacks < 3; c++) begin
      @(negedge clk);
      if (ifc_bus.ack) nacks++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (nacks !== 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got acks %0d busy %b expected 3 1", nacks, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ifc_bus.ack !== 1'b0 || uart_bus.ack !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: got busy %b acks %b%b owner %b expected 0 00 0",
               busy, ifc_bus.ack, uart_bus.ack, owner);
    end
    checks++;
    if (ifc_bus.rdata !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_rdata: got %h expected 0000", ifc_bus.rdata);
    end
    rst_n = 1'b1;
    nacks = 0; first_cyc = -1;
    for (int c = 1; c <= 60 && nacks < 5; c++) begin
      @(negedge clk);
      if (ifc_bus.ack || uart_bus.ack) begin
        if (nacks == 0) first_cyc = c;
        seq[nacks] = uart_bus.ack ? (ifc_bus.ack ? 2 : 1) : 0;
        nacks++;
      end
    end
    ifc_bus.req = 1'b0; uart_bus.req = 1'b0;
    @(negedge clk);
    checks++;
    if (nacks !== 5 || first_cyc !== 2 + RD_LAT) begin
      errors++;
      $display("FAIL regrant: got acks %0d first cycle %0d expected 5 %0d", nacks, first_cyc, 2 + RD_LAT);
    end
    for (int k = 0; k < nacks; k++) begin
      checks++;
      if (seq[k] !== ((k == STARVE_MAX) ? 1 : 0)) begin
        errors++;
        $display("FAIL post_reset_grant[%0d]: got port %0d expected %0d", k, seq[k], (k == STARVE_MAX) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_decode_err();
    test_both_same_edge();
    test_random();
    test_starve();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
